// File: rtl/speed_scheduler_if.sv
// Control and status bundle between the game logic and the speed scheduler.
// The master side drives the game controls and the divided clock feedback.
interface speed_scheduler_if;
  logic       start;
  logic       pause;
  logic       hit;
  logic       d_clock;
  logic [7:0] div_f;
  logic [3:0] level;
  logic       game_tick;
  logic       running;
  logic       game_over;

  modport master (
    output start, pause, hit, d_clock,
    input  div_f, level, game_tick, running, game_over
  );

  modport slave (
    input  start, pause, hit, d_clock,
    output div_f, level, game_tick, running, game_over
  );
endinterface

// File: rtl/speed_scheduler.sv
// Game-speed controller: emits one game_tick per divided-clock period in RUN and
// shortens the divide factor every TICKS_PER_LEVEL ticks, committing at a safe point.
module speed_scheduler #(
  parameter int unsigned BASE_DIV        = 200,
  parameter int unsigned MIN_DIV         = 40,
  parameter int unsigned STEP            = 16,
  parameter int unsigned TICKS_PER_LEVEL = 64,
  parameter int unsigned MAX_LEVEL       = 9
) (
  input logic               clk,
  input logic               rst,
  speed_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_OVER} state_e;

  localparam logic [7:0] BASE_F    = 8'(BASE_DIV);
  localparam logic [7:0] MIN_F     = 8'(MIN_DIV);
  localparam logic [7:0] STEP_F    = 8'(STEP);
  localparam logic [8:0] FLOOR_CMP = 9'(MIN_DIV + STEP);
  localparam logic [7:0] TPL_LAST  = 8'(TICKS_PER_LEVEL - 1);
  localparam logic [3:0] LVL_MAX   = 4'(MAX_LEVEL);

  state_e     state_q, state_d;
  logic [7:0] div_f_q, div_f_d;
  logic [3:0] level_q, level_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic       pending_q, pending_d;
  logic       game_tick_q, game_tick_d;
  logic       d_s_q, d_s_d;
  logic       d_p_q, d_p_d;
  logic       rise, fall;

  assign rise = d_s_q & ~d_p_q;
  assign fall = ~d_s_q & d_p_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    div_f_d     = div_f_q;
    level_d     = level_q;
    tick_cnt_d  = tick_cnt_q;
    pending_d   = pending_q;
    game_tick_d = 1'b0;
    d_s_d       = bus.d_clock;
    d_p_d       = d_s_q;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start && !bus.pause) begin
          state_d    = S_RUN;
          div_f_d    = BASE_F;
          level_d    = 4'd0;
          tick_cnt_d = 8'd0;
          pending_d  = 1'b0;
        end
      end
      S_RUN: begin
        // Commit only right after the divider wrapped to 0, so the new div_f is never below its count.
        if (fall && pending_q) begin
          level_d   = level_q + 4'd1;
          pending_d = 1'b0;
          div_f_d   = ({1'b0, div_f_q} >= FLOOR_CMP) ? div_f_q - STEP_F : MIN_F;
        end
        if (rise) begin
          game_tick_d = 1'b1;
          if (tick_cnt_q == TPL_LAST) begin
            tick_cnt_d = 8'd0;
            if (level_q < LVL_MAX) pending_d = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
        if (bus.hit) begin
          state_d = S_OVER;
          div_f_d = BASE_F;
        end else if (bus.pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (bus.hit) begin
          state_d = S_OVER;
          div_f_d = BASE_F;
        end else if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_f_q     <= BASE_F;
      level_q     <= 4'd0;
      tick_cnt_q  <= 8'd0;
      pending_q   <= 1'b0;
      game_tick_q <= 1'b0;
      d_s_q       <= 1'b0;
      d_p_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_f_q     <= div_f_d;
      level_q     <= level_d;
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      game_tick_q <= game_tick_d;
      d_s_q       <= d_s_d;
      d_p_q       <= d_p_d;
    end
  end

  assign bus.div_f     = div_f_q;
  assign bus.level     = level_q;
  assign bus.game_tick = game_tick_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_speed_scheduler.sv
// Scoreboard bench for speed_scheduler with a behavioural programmable divider
// closing the div_f -> d_clock loop (TICKS_PER_LEVEL=4, MAX_LEVEL=3, MIN_DIV=170).
module tb_speed_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  speed_scheduler_if bus();

  speed_scheduler #(
    .BASE_DIV(200), .MIN_DIV(170), .STEP(16), .TICKS_PER_LEVEL(4), .MAX_LEVEL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Divider: counts 0..div_f (8-bit, a missed compare wraps through 255), d_clock high in the upper half.
  logic [7:0] dcnt = 8'd0;
  always @(negedge clk) begin
    if (dcnt == bus.div_f) dcnt = 8'd0;
    else                   dcnt = dcnt + 8'd1;
    bus.d_clock = (dcnt >= (bus.div_f >> 1));
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int lvl;
    int div;
    int ivl;   // expected clk between this tick and the previous one, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_ticks = 0;
  int   last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int l, input int d, input int i);
    exp_t e;
    e.lvl = l; e.div = d; e.ivl = i;
    exp_q.push_back(e);
  endtask

  task automatic wait_left(input string name, input int left, input int budget);
    int k = 0;
    while (exp_q.size() > left && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, exp_q.size(), left);
  endtask

  // Monitor: every game_tick pops one expected record.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && bus.game_tick === 1'b1) begin
      n_ticks++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: got a game_tick expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("tick_level", bus.level, e.lvl);
        check("tick_div_f", bus.div_f, e.div);
        if (e.ivl != 0) check("tick_interval", cyc - last_cyc, e.ivl);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    int saved;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_div_f", bus.div_f, 200);
    check("rst_level", bus.level, 0);
    check("rst_tick", bus.game_tick, 0);
    check("rst_running", bus.running, 0);
    check("rst_over", bus.game_over, 0);

    @(negedge clk) rst = 1'b1;
    repeat (450) @(negedge clk);
    check("idle_running", bus.running, 0);
    check("idle_ticks", n_ticks, 0);

    // Start a game; level-up every 4 ticks, floor at 170, saturation at level 3.
    push(0, 200, 0);   push(0, 200, 201);
    push(0, 200, 0);   push(0, 200, 201);   // first tick after the pause has an odd interval
    push(1, 184, 193);
    for (int i = 0; i < 3; i++) push(1, 184, 185);
    push(2, 170, 178);
    for (int i = 0; i < 3; i++) push(2, 170, 171);
    for (int i = 0; i < 7; i++) push(3, 170, 171);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("start_running", bus.running, 1);
    check("start_level", bus.level, 0);

    wait_left("two_ticks", 17, 1000);

    // Pause mid-level: nothing moves, tick count preserved.
    repeat (10) @(negedge clk);
    bus.pause = 1'b1;
    saved = n_ticks;
    repeat (1000) @(negedge clk);
    check("pause_ticks", n_ticks, saved);
    check("pause_running", bus.running, 0);
    check("pause_level", bus.level, 0);
    check("pause_div_f", bus.div_f, 200);
    bus.pause = 1'b0;

    wait_left("run_drain", 0, 5000);
    @(negedge clk);
    check("sat_level", bus.level, 3);
    check("sat_div_f", bus.div_f, 170);

    // hit and pause together in RUN: hit wins.
    bus.hit = 1'b1;
    bus.pause = 1'b1;
    saved = n_ticks;
    @(negedge clk);
    bus.hit = 1'b0;
    bus.pause = 1'b0;
    check("over_flag", bus.game_over, 1);
    check("over_running", bus.running, 0);
    check("over_div_f", bus.div_f, 200);
    check("over_level", bus.level, 3);
    repeat (500) @(negedge clk);
    check("over_ticks", n_ticks, saved);
    check("over_hold", bus.game_over, 1);

    // Restart from OVER.
    push(0, 200, 0);
    for (int i = 0; i < 3; i++) push(0, 200, 201);
    push(1, 184, 193);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("restart_running", bus.running, 1);
    check("restart_over", bus.game_over, 0);
    check("restart_level", bus.level, 0);
    check("restart_div_f", bus.div_f, 200);
    wait_left("restart_drain", 0, 2000);
    @(negedge clk);
    check("l1_level", bus.level, 1);
    check("l1_div_f", bus.div_f, 184);

    // Asynchronous reset mid-game, between clock edges.
    repeat (37) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_div_f", bus.div_f, 200);
    check("midrst_level", bus.level, 0);
    check("midrst_running", bus.running, 0);
    check("midrst_tick", bus.game_tick, 0);
    check("midrst_over", bus.game_over, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_running", bus.running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
